if_id_queue: RTL and testbench
==============================

// Module: if_id_queue
// PURPOSE
//  Decoupling queue between instruction fetch and decode. Captures {pc, instr}
//  pairs from fetch under valid/ready handshake and presents them in order to
//  decode. A flush (driven from the jump/branch redirect, same cycle as
//  JumpFlag) discards all wrong-path entries. Absorbs decode stalls without
//  losing fetched instructions.
// PARAMETERS
//  DEPTH      2               entries; power of two, >= 2
//  NOP_INSTR  32'h0000_0013   instr driven on out_instr when out_valid=0 (addi x0,x0,0)
// PORTS
//  clk        in   1        rising-edge clock
//  rst_n      in   1        asynchronous, active-low reset
//  flush      in   1        discard all entries (redirect)
//  in_valid   in   1        fetch offers {in_pc, in_instr}
//  in_ready   out  1        queue accepts this cycle
//  in_pc      in   32       pc of offered instruction
//  in_instr   in   32       offered instruction word
//  out_valid  out  1        head entry valid
//  out_ready  in   1        decode consumes head this cycle
//  out_pc     out  32       pc of head entry
//  out_instr  out  32       head instruction word
//  count      out  $clog2(DEPTH)+1  current occupancy
// BEHAVIOUR
//  - Reset (async, rst_n=0): rd/wr pointers=0, count=0, out_valid=0, in_ready=1,
//    out_pc=0, out_instr=NOP_INSTR. Storage array need not be cleared.
//  - push = in_valid & in_ready & ~flush; pop = out_valid & out_ready & ~flush.
//  - in_ready = (count != DEPTH); registered-state only, never depends on
//    out_ready (no comb path decode->fetch). Full + pop same cycle: in_ready
//    stays 0, pop only, count -> DEPTH-1.
//  - out_valid = (count != 0); out_pc/out_instr = head entry; when
//    out_valid=0: out_pc=0, out_instr=NOP_INSTR.
//  - Latency: entry pushed at edge N is visible on out_* after edge N (1 cycle).
//  - push & pop same cycle (not full, not empty): both pointers advance,
//    count unchanged. Empty & push: count+1, nothing popped.
//  - Order strictly FIFO; pointers wrap modulo DEPTH; count never exceeds
//    DEPTH nor underflows (pop on empty impossible by construction).
//  - flush (synchronous, highest priority): at next edge pointers=0, count=0,
//    out_valid=0, in_ready=1; any push/pop presented in the flush cycle is
//    dropped. Flush on empty queue is a no-op. Flush for consecutive cycles
//    holds queue empty.
//  - Asserting rst_n=0 mid-operation clears immediately regardless of clk.
//  - Holding out_ready=0: head and out_* stable until popped or flushed.
// CONFIGURATION
//  IF_ID_QUEUE_BYPASS_EN defined: when count=0, in_valid=1 and flush=0, the
//    input passes combinationally: out_valid=1, out_pc=in_pc,
//    out_instr=in_instr. If out_ready=1 the pair is consumed and NOT written
//    (count stays 0); if out_ready=0 it is written as usual. Zero-cycle latency
//    on empty queue. in_ready remains registered-only.
//  Undefined: no bypass; empty queue always shows out_valid=0 (1-cycle latency).
// TESTING
//  1 Reset: rst_n=0 then release -> out_valid=0, in_ready=1, count=0,
//    out_instr=32'h00000013, out_pc=0.
//  2 Fill: out_ready=0, push pc 0x00/0x04 (instr 0xAAAA0001/0xAAAA0002) ->
//    count=2, in_ready=0, out_pc=0x00 held; 3rd offer (pc 0x08) not accepted.
//  3 Drain: then out_ready=1 -> out_pc 0x00 then 0x04 on successive cycles,
//    out_valid=0 after; pc 0x08 accepted once in_ready=1 and emerges third.
//  4 Stream: in_valid=1, out_ready=1, pc +4 each cycle from 0x00 for 20 cycles
//    -> count stays 1 (0 with bypass), out_pc sequence 0x00,0x04,... no gaps.
//  5 Flush: queue holding pc 0x10,0x14; flush=1 with in_valid=1 pc 0x40 ->
//    next cycle count=0, out_valid=0; pc 0x40 re-offered next cycle appears alone.
//  6 Bypass (IF_ID_QUEUE_BYPASS_EN): empty, in_valid=1 pc 0x80, out_ready=1 ->
//    same cycle out_valid=1 out_pc=0x80, count stays 0; without macro
//    out_valid=0 that cycle and out_pc=0x80 one cycle later.

Source files
------------

// File: rtl/if_id_queue.sv
// if_id_queue: decoupling FIFO between instruction fetch and decode.
// Holds {pc, instr} pairs under valid/ready handshakes on both sides.
// A synchronous flush empties the queue. in_ready depends only on
// registered occupancy, so there is no combinational path from decode
// back to fetch.
// Optional feature: define IF_ID_QUEUE_BYPASS_EN to let an offered pair
// pass straight through to decode when the queue is empty.
module if_id_queue #(
    parameter int unsigned DEPTH     = 2,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [31:0]                in_pc,
    input  logic [31:0]                in_instr,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [31:0]                out_pc,
    output logic [31:0]                out_instr,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [31:0]   pc_mem    [DEPTH];
    logic [31:0]   instr_mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count_q;

    logic empty;
    logic full;
    logic bypass_hit;
    logic bypass_take;
    logic push;
    logic pop;

    assign empty    = (count_q == '0);
    assign full     = (count_q == CW'(DEPTH));
    assign in_ready = ~full;
    assign count    = count_q;

`ifdef IF_ID_QUEUE_BYPASS_EN
    assign bypass_hit  = empty & in_valid & ~flush;
`else
    assign bypass_hit  = 1'b0;
`endif
    // A bypassed pair that decode takes immediately is never stored.
    assign bypass_take = bypass_hit & out_ready;

    assign push      = in_valid & in_ready & ~flush & ~bypass_take;
    assign pop       = ~empty & out_ready & ~flush;
    assign out_valid = ~empty | bypass_hit;

    // Pointer and occupancy state; flush has priority over push/pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else if (flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Entry storage; contents are only meaningful while counted as occupied.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr]    <= in_pc;
            instr_mem[wr_ptr] <= in_instr;
        end
    end

    // Head presentation: bypass pair, stored head, or idle NOP.
    always_comb begin
        out_pc    = '0;
        out_instr = NOP_INSTR;
        if (bypass_hit) begin
            out_pc    = in_pc;
            out_instr = in_instr;
        end else if (!empty) begin
            out_pc    = pc_mem[rd_ptr];
            out_instr = instr_mem[rd_ptr];
        end
    end

endmodule

// File: tb/tb_if_id_queue.sv
// tb_if_id_queue: directed self-checking bench for if_id_queue.
// A queue of expected {pc, instr} entries is pushed when the bench offers
// an accepted pair and popped/compared when decode consumes the head.
module tb_if_id_queue;

    localparam int unsigned DEPTH = 2;
    localparam logic [31:0] NOP   = 32'h0000_0013;
    localparam int unsigned CW    = $clog2(DEPTH) + 1;
`ifdef IF_ID_QUEUE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic          clk;
    logic          rst_n;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [31:0]   in_pc;
    logic [31:0]   in_instr;
    logic          out_valid;
    logic          out_ready;
    logic [31:0]   out_pc;
    logic [31:0]   out_instr;
    logic [CW-1:0] count;

    int tests;
    int fails;
    logic [63:0] sb [$];

    if_id_queue #(
        .DEPTH(DEPTH),
        .NOP_INSTR(NOP)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .flush(flush),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_pc(in_pc),
        .in_instr(in_instr),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_pc(out_pc),
        .out_instr(out_instr),
        .count(count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive one cycle from a negedge, check outputs, update the model, advance.
    task automatic step(input logic iv, input logic [31:0] pc, input logic [31:0] ins,
                        input logic ordy, input logic fl);
        int sz;
        logic byp, push, pop;
        logic [31:0] epc, ein;
        logic [63:0] e;
        in_valid  = iv;
        in_pc     = pc;
        in_instr  = ins;
        out_ready = ordy;
        flush     = fl;
        #1;
        sz  = sb.size();
        byp = BYP && (sz == 0) && iv && !fl;
        if (sz != 0) begin
            epc = sb[0][63:32];
            ein = sb[0][31:0];
        end else if (byp) begin
            epc = pc;
            ein = ins;
        end else begin
            epc = 32'h0;
            ein = NOP;
        end
        check("out_valid", {31'b0, out_valid}, {31'b0, (sz != 0) || byp});
        check("in_ready",  {31'b0, in_ready},  {31'b0, sz != int'(DEPTH)});
        check("count",     32'(count),         32'(sz));
        push = iv && (sz != int'(DEPTH)) && !fl && !(byp && ordy);
        pop  = (sz != 0) && ordy && !fl;
        if (fl) begin
            sb.delete();
        end else begin
            if (pop) begin
                e = sb.pop_front();
                check("pop_pc",    out_pc,    e[63:32]);
                check("pop_instr", out_instr, e[31:0]);
            end else begin
                check("head_pc",    out_pc,    epc);
                check("head_instr", out_instr, ein);
            end
            if (push) sb.push_back({pc, ins});
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        tests     = 0;
        fails     = 0;
        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_pc     = '0;
        in_instr  = '0;
        out_ready = 1'b0;
        #12;
        check("rst_count",     32'(count),            32'd0);
        check("rst_out_valid", {31'b0, out_valid},    32'd0);
        check("rst_in_ready",  {31'b0, in_ready},     32'd1);
        check("rst_out_instr", out_instr,             NOP);
        check("rst_out_pc",    out_pc,                32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

        // Fill with decode stalled; third offer must be refused.
        step(1'b1, 32'h00, 32'hAAAA_0001, 1'b0, 1'b0);
        step(1'b1, 32'h04, 32'hAAAA_0002, 1'b0, 1'b0);
        step(1'b1, 32'h08, 32'hAAAA_0003, 1'b0, 1'b0);
        step(1'b1, 32'h08, 32'hAAAA_0003, 1'b0, 1'b0);

        // Drain; full + pop pops only, then 0x08 enters behind 0x04.
        step(1'b1, 32'h08, 32'hAAAA_0003, 1'b1, 1'b0);
        step(1'b1, 32'h08, 32'hAAAA_0003, 1'b1, 1'b0);
        step(1'b0, 32'h0,  32'h0,         1'b1, 1'b0);
        step(1'b0, 32'h0,  32'h0,         1'b1, 1'b0);

        // Continuous stream.
        for (int i = 0; i < 20; i++)
            step(1'b1, 32'(i * 4), {16'hBEEF, 16'(i * 4)}, 1'b1, 1'b0);
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

        // Flush with a concurrent offer; re-offer emerges alone.
        step(1'b1, 32'h10, 32'hCCCC_0010, 1'b0, 1'b0);
        step(1'b1, 32'h14, 32'hCCCC_0014, 1'b0, 1'b0);
        step(1'b1, 32'h40, 32'hCCCC_0040, 1'b1, 1'b1);
        step(1'b1, 32'h40, 32'hCCCC_0040, 1'b0, 1'b0);
        step(1'b0, 32'h0,  32'h0,         1'b1, 1'b0);
        step(1'b0, 32'h0,  32'h0,         1'b1, 1'b0);

        // Consecutive flushes and flush on empty.
        step(1'b1, 32'h50, 32'hDDDD_0050, 1'b0, 1'b0);
        step(1'b1, 32'h54, 32'hDDDD_0054, 1'b0, 1'b1);
        step(1'b1, 32'h58, 32'hDDDD_0058, 1'b1, 1'b1);
        step(1'b0, 32'h0,  32'h0,         1'b1, 1'b1);
        step(1'b0, 32'h0,  32'h0,         1'b1, 1'b0);

        // Empty queue offered pc 0x80 with decode ready.
        step(1'b1, 32'h80, 32'hEEEE_0080, 1'b1, 1'b0);
        step(1'b0, 32'h0,  32'h0,         1'b1, 1'b0);
        step(1'b0, 32'h0,  32'h0,         1'b1, 1'b0);

        // Wrap pointers a few times with mixed stalls.
        for (int i = 0; i < 12; i++)
            step(1'b1, 32'h100 + 32'(i * 4), 32'h1234_0000 + 32'(i), 1'(i % 3 != 0), 1'b0);

        // Asynchronous reset between clock edges.
        step(1'b1, 32'h200, 32'h5555_0200, 1'b0, 1'b0);
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("async_count",     32'(count),         32'd0);
        check("async_out_valid", {31'b0, out_valid}, 32'd0);
        check("async_in_ready",  {31'b0, in_ready},  32'd1);
        check("async_out_instr", out_instr,          NOP);
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        step(1'b1, 32'h300, 32'h7777_0300, 1'b0, 1'b0);
        step(1'b0, 32'h0,   32'h0,         1'b1, 1'b0);
        step(1'b0, 32'h0,   32'h0,         1'b1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
